// File: rtl/key_event_detector_pkg.sv
// Shared types and constants for the debounced key-event path.
// Imported as key_event_pkg by the interface and the detector.
package key_event_pkg;

  typedef enum logic [0:0] {
    KEY_IDLE = 1'b0,
    KEY_DOWN = 1'b1
  } key_state_e;

  localparam int KEY_W = 8;
  localparam logic [KEY_W-1:0] KEY_NONE = 8'h00;

  // Counter only needs to reach cycles-1, so clog2(cycles) bits suffice.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_event_detector_if.sv
// Key-code input and press-event output bundle of the key event detector.
// master: detector side; slave: keyboard source / event consumer side.
interface key_event_detector_if;
  import key_event_pkg::*;

  logic [KEY_W-1:0] key;
  logic             ev_ready;
  logic             ev_valid;
  logic [KEY_W-1:0] ev_code;
  logic             ev_release;
  logic             pressed;
  logic             overflow;

  modport master (
    input  key,
    input  ev_ready,
    output ev_valid,
    output ev_code,
    output ev_release,
    output pressed,
    output overflow
  );

  modport slave (
    output key,
    output ev_ready,
    input  ev_valid,
    input  ev_code,
    input  ev_release,
    input  pressed,
    input  overflow
  );

endinterface

// File: rtl/key_event_detector_or_8_way.sv
// Eight-input OR reduction; used as the "key code is nonzero" test.
module or_8_way (
  input  logic [7:0] a,
  output logic       y
);

  assign y = |a;

endmodule

// File: rtl/key_event_detector.sv
// Debounced key-event generator: accepts a key code after DEBOUNCE_CYCLES
// identical samples and emits press events through a one-entry valid/ready
// register. Define KEY_EVENT_RELEASE_EN to also emit release events.
module key_event_detector
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  key_event_detector_if.master bus
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("key_event_detector: DEBOUNCE_CYCLES must be within 2..255");
  end

  logic [KEY_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] accepted;
  key_state_e       state_q;
  key_state_e       state_d;

  logic             key_eq;
  logic             stable;
  logic             accept;
  logic             cand_nz;
  logic             gen_ev;

  logic             ev_valid_q;
  logic [KEY_W-1:0] ev_code_q;
  logic             overflow_q;
  logic             ev_take;
  logic             ev_load;

`ifdef KEY_EVENT_RELEASE_EN
  logic             gen_rel;
  logic             ev_release_q;
`endif

  or_8_way u_cand_nz (
    .a (cand),
    .y (cand_nz)
  );

  assign key_eq = (bus.key == cand);
  assign stable = key_eq && (cnt == CNT_MAX);
  assign accept = stable && (cand != accepted);

  // Debounce: any differing sample restarts the count at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand <= KEY_NONE;
      cnt  <= '0;
    end else if (!key_eq) begin
      cand <= bus.key;
      cnt  <= CNT_W'(1);
    end else if (cnt < CNT_MAX) begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= KEY_IDLE;
      accepted <= KEY_NONE;
    end else begin
      state_q <= state_d;
      if (accept) accepted <= cand;
    end
  end

  always_comb begin
    state_d = state_q;
    gen_ev  = 1'b0;
`ifdef KEY_EVENT_RELEASE_EN
    gen_rel = 1'b0;
`endif
    case (state_q)
      KEY_IDLE: begin
        if (accept && cand_nz) begin
          state_d = KEY_DOWN;
          gen_ev  = 1'b1;
        end
      end
      KEY_DOWN: begin
        if (accept) begin
          if (cand_nz) begin
            gen_ev = 1'b1;
          end else begin
            state_d = KEY_IDLE;
`ifdef KEY_EVENT_RELEASE_EN
            gen_ev  = 1'b1;
            gen_rel = 1'b1;
`endif
          end
        end
      end
      default: state_d = KEY_IDLE;
    endcase
  end

  // Event register: a consumed slot can be refilled on the same edge.
  assign ev_take = ev_valid_q && bus.ev_ready;
  assign ev_load = gen_ev && (!ev_valid_q || bus.ev_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid_q <= 1'b0;
      ev_code_q  <= KEY_NONE;
      overflow_q <= 1'b0;
    end else begin
      if (ev_load) begin
        ev_valid_q <= 1'b1;
        ev_code_q  <= gen_ev_code();
      end else if (ev_take) begin
        ev_valid_q <= 1'b0;
      end
      if (gen_ev && !ev_load) overflow_q <= 1'b1;
    end
  end

  // Releases carry the previously accepted code, presses the new candidate.
  function automatic logic [KEY_W-1:0] gen_ev_code();
`ifdef KEY_EVENT_RELEASE_EN
    return gen_rel ? accepted : cand;
`else
    return cand;
`endif
  endfunction

`ifdef KEY_EVENT_RELEASE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_release_q <= 1'b0;
    end else if (ev_load) begin
      ev_release_q <= gen_rel;
    end
  end
  assign bus.ev_release = ev_release_q;
`else
  assign bus.ev_release = 1'b0;
`endif

  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_code  = ev_code_q;
  assign bus.overflow = overflow_q;
  assign bus.pressed  = (state_q == KEY_DOWN);

endmodule

// File: tb/tb_key_event_detector.sv
// Directed bench for key_event_detector with DEBOUNCE_CYCLES=4.
module tb_key_event_detector;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  key_event_detector_if bus ();

  key_event_detector #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"},    32'(bus.ev_valid),   32'd0);
    chk({tag, "_code"},     32'(bus.ev_code),    32'd0);
    chk({tag, "_release"},  32'(bus.ev_release), 32'd0);
    chk({tag, "_pressed"},  32'(bus.pressed),    32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow),   32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.key      = 8'h00;
    bus.ev_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    chk_idle_outputs("reset");

    // Press 0x41: not yet after 3 edges, event after the 4th.
    bus.key = 8'h41;
    tick(3);
    chk("press_early_valid",   32'(bus.ev_valid), 32'd0);
    chk("press_early_pressed", 32'(bus.pressed),  32'd0);
    tick(1);
    chk("press_valid",   32'(bus.ev_valid),   32'd1);
    chk("press_code",    32'(bus.ev_code),    32'h41);
    chk("press_release", 32'(bus.ev_release), 32'd0);
    chk("press_pressed", 32'(bus.pressed),    32'd1);
    tick(2);
    chk("press_hold_code",     32'(bus.ev_code),  32'h41);
    chk("press_hold_overflow", 32'(bus.overflow), 32'd0);
    bus.ev_ready = 1'b1;
    tick(1);
    bus.ev_ready = 1'b0;
    chk("press_consumed", 32'(bus.ev_valid), 32'd0);

    // Release.
    bus.key = 8'h00;
    tick(3);
    chk("rel_early_pressed", 32'(bus.pressed), 32'd1);
    tick(1);
    chk("rel_pressed", 32'(bus.pressed), 32'd0);
`ifdef KEY_EVENT_RELEASE_EN
    chk("rel_valid",   32'(bus.ev_valid),   32'd1);
    chk("rel_code",    32'(bus.ev_code),    32'h41);
    chk("rel_release", 32'(bus.ev_release), 32'd1);
    bus.ev_ready = 1'b1;
    tick(1);
    bus.ev_ready = 1'b0;
    chk("rel_consumed", 32'(bus.ev_valid), 32'd0);
`else
    chk("rel_no_event", 32'(bus.ev_valid), 32'd0);
`endif

    // Glitch: 3 samples of 0x41 then back to 0.
    bus.key = 8'h41;
    tick(3);
    bus.key = 8'h00;
    tick(5);
    chk("glitch_valid",    32'(bus.ev_valid), 32'd0);
    chk("glitch_pressed",  32'(bus.pressed),  32'd0);
    chk("glitch_overflow", 32'(bus.overflow), 32'd0);

    // Roll-over 0x41 -> 0x42.
    bus.key = 8'h41;
    tick(4);
    chk("roll_first_code", 32'(bus.ev_code), 32'h41);
    bus.ev_ready = 1'b1;
    tick(1);
    bus.ev_ready = 1'b0;
    bus.key = 8'h42;
    tick(3);
    chk("roll_mid_pressed", 32'(bus.pressed),  32'd1);
    chk("roll_mid_valid",   32'(bus.ev_valid), 32'd0);
    tick(1);
    chk("roll_valid",   32'(bus.ev_valid),   32'd1);
    chk("roll_code",    32'(bus.ev_code),    32'h42);
    chk("roll_release", 32'(bus.ev_release), 32'd0);
    chk("roll_pressed", 32'(bus.pressed),    32'd1);
    bus.ev_ready = 1'b1;
    tick(1);
    bus.ev_ready = 1'b0;

    // Backpressure: roll-over event dropped while 0x41 is held.
    bus.key = 8'h41;
    tick(4);
    chk("bp_first_code", 32'(bus.ev_code), 32'h41);
    bus.key = 8'h42;
    tick(4);
    chk("bp_valid",    32'(bus.ev_valid), 32'd1);
    chk("bp_code",     32'(bus.ev_code),  32'h41);
    chk("bp_overflow", 32'(bus.overflow), 32'd1);

    // Same sequence, consumer ready on the load edge: no bubble, no drop.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("bp_reset_overflow", 32'(bus.overflow), 32'd0);
    bus.key = 8'h41;
    tick(4);
    chk("ng_first_code", 32'(bus.ev_code), 32'h41);
    bus.key = 8'h42;
    tick(3);
    bus.ev_ready = 1'b1;
    tick(1);
    bus.ev_ready = 1'b0;
    chk("ng_valid",    32'(bus.ev_valid), 32'd1);
    chk("ng_code",     32'(bus.ev_code),  32'h42);
    chk("ng_overflow", 32'(bus.overflow), 32'd0);

    // Reset with cnt=2 and an event pending.
    bus.key = 8'h41;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_idle_outputs("midrst");
    tick(3);
    chk("midrst_early_valid", 32'(bus.ev_valid), 32'd0);
    tick(1);
    chk("midrst_valid",   32'(bus.ev_valid), 32'd1);
    chk("midrst_code",    32'(bus.ev_code),  32'h41);
    chk("midrst_pressed", 32'(bus.pressed),  32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
